// File: rtl/data_req_responder.sv
// In-order responder for the data req/addr_ok/data_ok handshake, backed by a 1-cycle-latency SRAM port.
// Optional misaligned-access check is enabled by defining DATA_RESP_ALIGN_CHK_EN.
module data_req_responder #(
    parameter int ADDR_W   = 32,
    parameter int DEPTH    = 2,
    parameter int WAIT_CYC = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [3:0]        data_wstrb,
    input  logic [31:0]       data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [31:0]       data_rdata,
    output logic              resp_err,
    input  logic              cancel_req,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int WAIT_W = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;

    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'((WAIT_CYC > 0) ? WAIT_CYC - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t state, state_next;
    logic [WAIT_W-1:0] wait_cnt;

    logic              q_wr        [DEPTH];
    logic [1:0]        q_size      [DEPTH];
    logic [ADDR_W-1:0] q_addr      [DEPTH];
    logic [3:0]        q_wstrb     [DEPTH];
    logic [31:0]       q_wdata     [DEPTH];
    logic              q_cancelled [DEPTH];

    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count, count_next;
    logic             push, pop;

    logic              h_wr, h_cancelled, h_misaligned;
    logic [1:0]        h_size;
    logic [ADDR_W-1:0] h_addr;
    logic [3:0]        h_wstrb;
    logic [31:0]       h_wdata;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // Fullness uses the registered count, so a pop in the same cycle never frees a slot early.
    assign data_addr_ok = !reset && (count < CNT_FULL);
    assign push         = data_req && data_addr_ok;
    assign pop          = (state == S_RESP);

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + 1'b1;
        end else if (!push && pop) begin
            count_next = count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count_next;
        end
    end

    // A push never lands on the head slot while the queue is non-empty, so the two writes cannot collide.
    always_ff @(posedge clk) begin
        if (push) begin
            q_wr[wr_ptr]        <= data_wr;
            q_size[wr_ptr]      <= data_size;
            q_addr[wr_ptr]      <= data_addr;
            q_wstrb[wr_ptr]     <= data_wstrb;
            q_wdata[wr_ptr]     <= data_wdata;
            q_cancelled[wr_ptr] <= 1'b0;
        end
        if (!reset && cancel_req && (count != '0)) begin
            q_cancelled[rd_ptr] <= 1'b1;
        end
    end

    assign h_wr        = q_wr[rd_ptr];
    assign h_size      = q_size[rd_ptr];
    assign h_addr      = q_addr[rd_ptr];
    assign h_wstrb     = q_wstrb[rd_ptr];
    assign h_wdata     = q_wdata[rd_ptr];
    assign h_cancelled = q_cancelled[rd_ptr];

`ifdef DATA_RESP_ALIGN_CHK_EN
    assign h_misaligned = ((h_size == 2'd1) && h_addr[0]) ||
                          ((h_size == 2'd2) && (h_addr[1:0] != 2'b00));
`else
    logic unused_size;
    assign unused_size  = ^h_size;
    assign h_misaligned = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
        end else begin
            state <= state_next;
            if (state_next == S_WAIT && state != S_WAIT) begin
                wait_cnt <= WAIT_LOAD;
            end else if (state == S_WAIT && wait_cnt != '0) begin
                wait_cnt <= wait_cnt - 1'b1;
            end
        end
    end

    // A request pushed this cycle counts as queued work, giving ACCESS one cycle after acceptance.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (count != '0 || push) begin
                    state_next = (WAIT_CYC == 0) ? S_ACCESS : S_WAIT;
                end
            end
            S_WAIT: begin
                if (wait_cnt == '0) state_next = S_ACCESS;
            end
            S_ACCESS: state_next = S_RESP;
            S_RESP: begin
                if (count_next != '0) begin
                    state_next = (WAIT_CYC == 0) ? S_ACCESS : S_WAIT;
                end else begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        ram_en       = 1'b0;
        ram_we       = 4'b0;
        ram_addr     = '0;
        ram_wdata    = 32'h0;
        data_data_ok = 1'b0;
        data_rdata   = 32'h0;
        resp_err     = 1'b0;
        if (!reset) begin
            case (state)
                S_ACCESS: begin
                    ram_en    = !h_cancelled && !cancel_req && !h_misaligned;
                    ram_we    = (ram_en && h_wr) ? h_wstrb : 4'b0;
                    ram_addr  = {h_addr[ADDR_W-1:2], 2'b00};
                    ram_wdata = h_wdata;
                end
                S_RESP: begin
                    data_data_ok = !h_cancelled && !cancel_req;
                    data_rdata   = (h_wr || h_misaligned) ? 32'h0 : ram_rdata;
                    resp_err     = data_data_ok && h_misaligned;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_data_req_responder.sv
// Bench for data_req_responder: directed scenarios plus randomized traffic against a transaction-level
// model (per-request access/response cycles, cancellation and a reference memory).
`timescale 1ns/1ps
module tb_data_req_responder;
    localparam int DEPTH = 2;
    localparam int W     = 0;

    logic        clk = 1'b0;
    logic        reset;
    logic        data_req, data_wr, cancel_req;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, data_rdata, ram_addr, ram_wdata, ram_rdata;
    logic [3:0]  data_wstrb, ram_we;
    logic        data_addr_ok, data_data_ok, resp_err, ram_en;

    logic        s_req, s_wr, s_cancel, s_addr_ok, s_data_ok, s_resp_err, s_ram_en;
    logic [1:0]  s_size;
    logic [31:0] s_addr, s_wdata, s_rdata, s_ram_addr, s_ram_wdata, s_ram_rdata;
    logic [3:0]  s_wstrb, s_ram_we;

    logic [31:0] ram_mem   [256];
    logic [31:0] model_mem [256];
    logic [31:0] slow_mem  [16];

    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;
    int wr_en_cnt = 0;
    int en_cnt = 0;
    int resp_cnt = 0;

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        bit          cancelled;
        int          acc_c;
        int          resp_c;
        logic [31:0] rdata;
    } ent_t;

    ent_t mq[$];
    int   last_resp = -100;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_req_responder #(.ADDR_W(32), .DEPTH(DEPTH), .WAIT_CYC(W)) u_dut (
        .clk(clk), .reset(reset), .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .resp_err(resp_err), .cancel_req(cancel_req), .ram_en(ram_en), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    data_req_responder #(.ADDR_W(32), .DEPTH(2), .WAIT_CYC(3)) u_slow (
        .clk(clk), .reset(reset), .data_req(s_req), .data_wr(s_wr), .data_size(s_size),
        .data_addr(s_addr), .data_wstrb(s_wstrb), .data_wdata(s_wdata),
        .data_addr_ok(s_addr_ok), .data_data_ok(s_data_ok), .data_rdata(s_rdata),
        .resp_err(s_resp_err), .cancel_req(s_cancel), .ram_en(s_ram_en), .ram_we(s_ram_we),
        .ram_addr(s_ram_addr), .ram_wdata(s_ram_wdata), .ram_rdata(s_ram_rdata)
    );

    always @(posedge clk) begin : bench_ram
        logic [31:0] w;
        if (ram_en) begin
            if (ram_we == 4'b0) begin
                ram_rdata <= ram_mem[ram_addr[9:2]];
            end else begin
                w = ram_mem[ram_addr[9:2]];
                for (int b = 0; b < 4; b++) if (ram_we[b]) w[8*b +: 8] = ram_wdata[8*b +: 8];
                ram_mem[ram_addr[9:2]] = w;
            end
        end
    end

    always @(posedge clk) begin
        if (s_ram_en && s_ram_we == 4'b0) s_ram_rdata <= slow_mem[s_ram_addr[5:2]];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, {31'b0, act}, {31'b0, exp});
    endtask

    function automatic bit misaligned(input logic [1:0] sz, input logic [31:0] a);
`ifdef DATA_RESP_ALIGN_CHK_EN
        return ((sz == 2'd1) && a[0]) || ((sz == 2'd2) && (a[1:0] != 2'b00));
`else
        return (^{sz, a}) & 1'b0;
`endif
    endfunction

    // Each accepted request gets its access and response cycle from a single-server schedule.
    always @(negedge clk) begin : compare
        ent_t        h;
        ent_t        n;
        int          qn;
        int          s;
        bit          hv, mis, exp_en, exp_ok;
        logic [31:0] w;
        if (ram_en) en_cnt++;
        if (ram_en && ram_we != 4'b0) wr_en_cnt++;
        if (data_data_ok) resp_cnt++;
        if (reset) begin
            chk1("rst_addr_ok", data_addr_ok, 1'b0);
            chk1("rst_data_ok", data_data_ok, 1'b0);
            chk1("rst_ram_en", ram_en, 1'b0);
            chk1("rst_resp_err", resp_err, 1'b0);
            chk("rst_ram_we", {28'b0, ram_we}, 32'h0);
            chk("rst_ram_addr", ram_addr, 32'h0);
            chk("rst_rdata", data_rdata, 32'h0);
            mq.delete();
            last_resp = -100;
        end else begin
            qn = mq.size();
            chk1("addr_ok", data_addr_ok, qn < DEPTH);
            hv = (qn > 0);
            if (hv && cancel_req) begin
                h = mq[0];
                h.cancelled = 1'b1;
                mq[0] = h;
            end
            if (hv) h = mq[0];
            mis    = hv && misaligned(h.size, h.addr);
            exp_en = hv && (h.acc_c == cyc) && !h.cancelled && !mis;
            chk1("ram_en", ram_en, exp_en);
            if (exp_en) begin
                chk("ram_we", {28'b0, ram_we}, {28'b0, (h.wr ? h.wstrb : 4'b0)});
                chk("ram_addr", ram_addr, h.addr & 32'hFFFF_FFFC);
                chk("ram_wdata", ram_wdata, h.wdata);
                if (h.wr) begin
                    w = model_mem[h.addr[9:2]];
                    for (int b = 0; b < 4; b++) if (h.wstrb[b]) w[8*b +: 8] = h.wdata[8*b +: 8];
                    model_mem[h.addr[9:2]] = w;
                end else begin
                    h.rdata = model_mem[h.addr[9:2]];
                    mq[0] = h;
                end
            end
            exp_ok = hv && (h.resp_c == cyc) && !h.cancelled;
            chk1("data_ok", data_data_ok, exp_ok);
            if (exp_ok) begin
                chk("rdata", data_rdata, (h.wr || mis) ? 32'h0 : h.rdata);
                chk1("resp_err", resp_err, mis);
            end else begin
                chk1("resp_err_idle", resp_err, 1'b0);
            end
            if (hv && h.resp_c == cyc) void'(mq.pop_front());
            if (data_req && qn < DEPTH) begin
                s = (cyc + 1 > last_resp + 1) ? cyc + 1 : last_resp + 1;
                n.wr = data_wr;  n.size = data_size;  n.addr = data_addr;
                n.wstrb = data_wstrb;  n.wdata = data_wdata;  n.cancelled = 1'b0;
                n.acc_c = s + W;  n.resp_c = s + W + 1;  n.rdata = 32'h0;
                last_resp = n.resp_c;
                mq.push_back(n);
            end
        end
    end

    task automatic send(input logic wr, input logic [1:0] sz, input logic [31:0] a,
                        input logic [3:0] st, input logic [31:0] wd, output int acc_at);
        data_req = 1'b1; data_wr = wr; data_size = sz; data_addr = a;
        data_wstrb = st; data_wdata = wd;
        acc_at = -1;
        for (int i = 0; i < 50 && acc_at < 0; i++) begin
            @(negedge clk);
            if (data_addr_ok) acc_at = cyc;
            @(posedge clk); #1;
        end
        data_req = 1'b0;
        if (acc_at < 0) chk1("accept_timeout", 1'b0, 1'b1);
    endtask

    task automatic wait_ok(output int at, output logic [31:0] d, output logic e);
        at = -1; d = 32'h0; e = 1'b0;
        for (int i = 0; i < 50 && at < 0; i++) begin
            @(negedge clk);
            if (data_data_ok) begin
                at = cyc; d = data_rdata; e = resp_err;
            end
        end
        @(posedge clk); #1;
        if (at < 0) chk1("resp_timeout", 1'b0, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int          t, r, t2, w0, r0, e0, ena;
        int          acc[3];
        int          k;
        logic [31:0] d, v;
        logic        e, last_ok;

        for (int i = 0; i < 256; i++) begin
            v = $urandom;
            ram_mem[i] = v;
            model_mem[i] = v;
        end
        ram_mem[8'h40] = 32'hDEADBEEF;  model_mem[8'h40] = 32'hDEADBEEF;
        ram_mem[8'h10] = 32'hAAAAAAAA;  model_mem[8'h10] = 32'hAAAAAAAA;
        ram_mem[8'h20] = 32'h55AA55AA;  model_mem[8'h20] = 32'h55AA55AA;
        for (int i = 0; i < 16; i++) slow_mem[i] = 32'h0;
        slow_mem[2] = 32'hCAFEF00D;
        ram_rdata = 32'h0; s_ram_rdata = 32'h0;
        reset = 1'b1; data_req = 1'b0; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h0;
        data_wstrb = 4'h0; data_wdata = 32'h0; cancel_req = 1'b0;
        s_req = 1'b0; s_wr = 1'b0; s_size = 2'd2; s_addr = 32'h0; s_wstrb = 4'h0;
        s_wdata = 32'h0; s_cancel = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;

        // Single load: two-cycle latency
        send(1'b0, 2'd2, 32'h100, 4'h0, 32'h0, t);
        wait_ok(r, d, e);
        chk("t1_latency", r - t, 32'd2);
        chk("t1_data", d, 32'hDEADBEEF);

        // Partial store then load
        w0 = wr_en_cnt;
        send(1'b1, 2'd2, 32'h40, 4'b0011, 32'h12345678, t);
        wait_ok(r, d, e);
        chk("t2_write_count", wr_en_cnt - w0, 32'd1);
        send(1'b0, 2'd2, 32'h40, 4'h0, 32'h0, t);
        wait_ok(r, d, e);
        chk("t2_merged", d, 32'hAAAA5678);

        // Back-pressure with three back-to-back loads
        r0 = resp_cnt;
        k = 0;
        data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h0;
        for (int i = 0; i < 20 && k < 3; i++) begin
            @(negedge clk);
            if (data_addr_ok) begin
                acc[k] = cyc;
                k++;
            end
            @(posedge clk); #1;
            data_addr = k * 4;
        end
        data_req = 1'b0;
        chk("t3_accepted", k, 32'd3);
        chk("t3_second_gap", acc[1] - acc[0], 32'd1);
        chk("t3_third_gap", acc[2] - acc[0], 32'd3);
        repeat (4) @(posedge clk);
        #1;
        chk("t3_responses", resp_cnt - r0, 32'd3);

        // Cancelled store, then a load of the same word
        w0 = wr_en_cnt; r0 = resp_cnt;
        send(1'b1, 2'd2, 32'h80, 4'b1111, 32'hFFFFFFFF, t);
        cancel_req = 1'b1;
        @(posedge clk); #1;
        cancel_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("t4_no_write", wr_en_cnt - w0, 32'd0);
        chk("t4_no_resp", resp_cnt - r0, 32'd0);
        send(1'b0, 2'd2, 32'h80, 4'h0, 32'h0, t);
        wait_ok(r, d, e);
        chk("t4_load", d, 32'h55AA55AA);

        // Slow instance: three wait cycles
        s_addr = 32'h8; s_req = 1'b1; t2 = -1;
        for (int i = 0; i < 10 && t2 < 0; i++) begin
            @(negedge clk);
            if (s_addr_ok) t2 = cyc;
            @(posedge clk); #1;
        end
        s_req = 1'b0;
        ena = -1; r = -1; d = 32'h0; e = 1'b0;
        for (int i = 0; i < 20 && r < 0; i++) begin
            @(negedge clk);
            if (s_ram_en && ena < 0) ena = cyc;
            if (s_data_ok) begin
                r = cyc; d = s_rdata; e = s_resp_err;
            end
        end
        @(posedge clk); #1;
        chk("t5_ram_en_at", ena - t2, 32'd4);
        chk("t5_latency", r - t2, 32'd5);
        chk("t5_data", d, 32'hCAFEF00D);
        chk1("t5_err", e, 1'b0);

        // Half load at an odd address
        e0 = en_cnt;
        send(1'b0, 2'd1, 32'h103, 4'h0, 32'h0, t);
        wait_ok(r, d, e);
`ifdef DATA_RESP_ALIGN_CHK_EN
        chk("t6_ram_en", en_cnt - e0, 32'd0);
        chk1("t6_err", e, 1'b1);
        chk("t6_data", d, 32'h0);
`else
        chk("t6_ram_en", en_cnt - e0, 32'd1);
        chk1("t6_err", e, 1'b0);
        chk("t6_data", d, 32'hDEADBEEF);
`endif

        // Randomized traffic with cancels and a mid-run reset
        last_ok = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if (i == 400 || i == 401) begin
                reset = 1'b1; data_req = 1'b0; cancel_req = 1'b0;
            end else begin
                reset = 1'b0;
                if (!(data_req && !last_ok)) begin
                    data_req   = ($urandom_range(0, 99) < 60);
                    data_wr    = $urandom_range(0, 1);
                    data_size  = $urandom_range(0, 2);
                    data_addr  = $urandom_range(0, 1023);
                    data_wstrb = $urandom_range(0, 15);
                    data_wdata = $urandom;
                end
                cancel_req = ($urandom_range(0, 99) < 8);
            end
            @(negedge clk);
            last_ok = data_addr_ok;
            @(posedge clk); #1;
        end
        data_req = 1'b0; cancel_req = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/data_req_responder.md
Name: data_req_responder

Overview:
- Responder end of the pipeline's data request/response handshake.
  - Accepts load/store requests issued from EX: addr phase via `data_addr_ok`.
  - Answers the MEM stage with `data_data_ok`/`data_rdata`, in order.
- Backend is a synchronous SRAM-style port with fixed 1-cycle read latency.
- Serves as the uncached/no-dcache data path and as the bench memory model for the pipeline.

Parameters:
- ADDR_W, 32, width of request and RAM address.
- DEPTH, 2, max outstanding (accepted, not yet answered) requests; power of 2, >= 1.
- WAIT_CYC, 0, extra wait cycles inserted before each RAM access (slow-memory model).

Ports:
- clk, input, 1, clock.
- reset, input, 1, synchronous, active-high.
- data_req, input, 1, request valid.
- data_wr, input, 1, 1 = store, 0 = load.
- data_size, input, 2, 0 = byte, 1 = half, 2 = word.
- data_addr, input, ADDR_W, byte address.
- data_wstrb, input, 4, store byte enables.
- data_wdata, input, 32, store data.
- data_addr_ok, output, 1, request accepted this cycle when data_req is high.
- data_data_ok, output, 1, one-cycle response pulse for the oldest request.
- data_rdata, output, 32, load data, full word (MEM stage extracts bytes).
- resp_err, output, 1, error flag qualified by data_data_ok.
- cancel_req, input, 1, cancels the oldest outstanding request (TLB exception in MEM).
- ram_en, output, 1, RAM access enable.
- ram_we, output, 4, RAM byte write enables.
- ram_addr, output, ADDR_W, word-aligned address (low 2 bits forced 0).
- ram_wdata, output, 32, RAM write data.
- ram_rdata, input, 32, RAM read data, valid the cycle after ram_en with ram_we = 0.

Behaviour:
- Reset values: all outputs 0; queue empty; FSM in IDLE; wait counter 0.
- Request queue:
  - Circular FIFO of DEPTH entries: {wr, size, addr, wstrb, wdata, cancelled}; count register 0..DEPTH.
  - data_addr_ok = !reset && count < DEPTH. Full is evaluated on the registered count; a pop in the same cycle does not free a slot.
  - Push on data_req && data_addr_ok. Push and pop in the same cycle leave count unchanged.
  - Pointers wrap at DEPTH.
- FSM states, head = oldest entry:
  - IDLE:
    - queue non-empty and WAIT_CYC == 0 -> ACCESS.
    - queue non-empty and WAIT_CYC > 0 -> WAIT, counter loaded with WAIT_CYC-1.
  - WAIT: counter decrements each cycle; at 0 -> ACCESS.
  - ACCESS:
    - ram_en = !head.cancelled && !cancel_req.
    - ram_we = head.wr ? head.wstrb : 0; ram_addr = head.addr with [1:0] = 0; ram_wdata = head.wdata.
    - Always -> RESP next cycle.
  - RESP:
    - data_data_ok = !head.cancelled && !cancel_req.
    - data_rdata = ram_rdata for loads, 0 for stores.
    - Head is popped.
    - Next state: ACCESS if another entry remains and WAIT_CYC == 0; WAIT if an entry remains and WAIT_CYC > 0; else IDLE.
- Latency with WAIT_CYC = 0, request accepted at cycle T:
  - ACCESS at T+1, data_data_ok at T+2.
  - Steady-state throughput: 1 response per 2 cycles.
  - Each WAIT_CYC adds 1 cycle.
- Cancel:
  - cancel_req applies only to the head.
  - Head in queue/WAIT: sets head.cancelled. That request never drives ram_en and never produces data_data_ok, but still occupies its FSM slot.
  - Head in ACCESS: gates ram_en combinationally, so a cancelled store never writes.
  - Head in RESP: suppresses data_data_ok.
  - cancel_req with an empty queue is ignored.
- Response ordering: strictly in acceptance order.
- data_data_ok is never asserted for more than one cycle per request.
- resp_err is 0 whenever data_data_ok is 0.
- reset mid-operation: queue flushed and outstanding requests dropped without response; any pending write is discarded.

Optional Feature:
- Macro DATA_RESP_ALIGN_CHK_EN.
- Defined:
  - An entry is misaligned if size 1 with addr[0] = 1, or size 2 with addr[1:0] != 0.
  - A misaligned entry in ACCESS drives ram_en = 0.
  - In RESP it drives data_data_ok = 1 (unless cancelled), resp_err = 1, data_rdata = 0.
- Undefined: no check is made; resp_err is tied to 0; misaligned requests access the word-aligned address.

Test Plan:
- Read, WAIT_CYC=0: RAM[0x100] = 0xDEADBEEF, load addr 0x100 accepted at T -> ram_en at T+1, data_data_ok at T+2 with data_rdata = 0xDEADBEEF.
- Write then read: store 0x12345678 to 0x40 with wstrb = 4'b0011, then load 0x40 with RAM preset 0xAAAAAAAA -> ram_we = 0011 once; load returns 0xAAAA5678.
- Back-pressure, DEPTH=2: data_req held high for 3 requests -> addr_ok high for the first two, low for the third until the first RESP pop; exactly 3 data_data_ok pulses, in order.
- Cancel: store to 0x80 accepted, cancel_req pulsed the cycle after acceptance -> no ram_en with nonzero ram_we, no data_data_ok; a following load is answered normally.
- Slow memory, WAIT_CYC=3: single load accepted at T -> data_data_ok at T+5.
- Misaligned access with DATA_RESP_ALIGN_CHK_EN defined: half load at 0x103 -> ram_en stays 0; data_data_ok with resp_err = 1 and data_rdata = 0.
